// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate block: FSM state encoding,
// term-counter width and a saturating counter increment helper.
package mac_pkg;

  localparam int MAC_CNT_W = 8;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } mac_state_e;

  // Increment that sticks at the all-ones value.
  function automatic logic [MAC_CNT_W-1:0] sat_inc(input logic [MAC_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/multiplyer.sv
// Combinational unsigned WIDTH_IN x WIDTH_IN multiplier with a full-width product.
module multiplyer #(
  parameter int WIDTH_IN = 8
) (
  input  logic [WIDTH_IN-1:0]   a_i,
  input  logic [WIDTH_IN-1:0]   b_i,
  output logic [2*WIDTH_IN-1:0] p_o
);

  assign p_o = a_i * b_i;

endmodule

// File: rtl/mac_accumulator.sv
// Three-stage unsigned multiply-accumulate with valid/ready handshakes.
// S1 registers operands, S2 registers the product, S3 accumulates.
// Build option: define MAC_ACCUMULATOR_SAT_EN to clamp the accumulator on
// overflow instead of wrapping; the sticky overflow flag is set either way.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACC   | accepting operand beats
// DRAIN | last beat taken, waiting for its product to reach the accumulator
// OUT   | result presented, waiting for out_ready
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int WIDTH_IN = 8,
  parameter int ACC_W    = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_IN-1:0]  in_a,
  input  logic [WIDTH_IN-1:0]  in_b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_acc,
  output logic [MAC_CNT_W-1:0] out_count,
  output logic                 overflow
);

  localparam int PROD_W = 2 * WIDTH_IN;

  mac_state_e state_q, state_d;

  logic                 accept;
  logic                 xfer;

  logic [WIDTH_IN-1:0]  s1_a_q, s1_b_q;
  logic                 s1_last_q, s1_valid_q;

  logic [PROD_W-1:0]    prod;
  logic [PROD_W-1:0]    s2_prod_q;
  logic                 s2_last_q, s2_valid_q;

  logic [ACC_W:0]       sum_ext;
  logic                 carry;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [MAC_CNT_W-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 s3_last_q, s3_last_d;

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;

  // S1: capture an accepted operand beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_last_q <= in_last;
        s1_a_q    <= in_a;
        s1_b_q    <= in_b;
      end
    end
  end

  multiplyer #(
    .WIDTH_IN (WIDTH_IN)
  ) u_mult (
    .a_i (s1_a_q),
    .b_i (s1_b_q),
    .p_o (prod)
  );

  // S2: register the product alongside its tag bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_prod_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_last_q <= s1_last_q;
        s2_prod_q <= prod;
      end
    end
  end

  // The carry out of the one-bit-wider add is the overflow event.
  assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, s2_prod_q};
  assign carry   = sum_ext[ACC_W];

  // S3 next state: clear on result transfer, otherwise accumulate valid products.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    s3_last_d = s3_last_q;
    if (xfer) begin
      acc_d     = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      s3_last_d = 1'b0;
    end else if (s2_valid_q) begin
`ifdef MAC_ACCUMULATOR_SAT_EN
      acc_d = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
      acc_d = sum_ext[ACC_W-1:0];
`endif
      cnt_d = sat_inc(cnt_q);
      ovf_d = ovf_q | carry;
      if (s2_last_q) begin
        s3_last_d = 1'b1;
      end
    end
  end

  // S3 registers: accumulator, term count, sticky overflow, last-added marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      s3_last_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      s3_last_q <= s3_last_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (s3_last_q)         state_d = OUT;
      OUT:     if (xfer)              state_d = ACC;
      default:                        state_d = ACC;
    endcase
  end

  // FSM outputs: handshake controls.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACC:     in_ready  = 1'b1;
      OUT:     out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_acc   = acc_q;
  assign out_count = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator with ACC_W = 24.
module tb_mac_accumulator;

  localparam int ACC_W = 24;

`ifdef MAC_ACCUMULATOR_SAT_EN
  localparam logic [ACC_W-1:0] OVF_ACC = 24'hFFFFFF;
`else
  // 259 * 65025 = 16841475, minus 2^24
  localparam logic [ACC_W-1:0] OVF_ACC = 24'd64259;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_last;
  logic [7:0]       in_a, in_b;
  logic             out_valid, out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [7:0]       out_count;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [7:0]       cnt;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  mac_accumulator #(
    .WIDTH_IN (8),
    .ACC_W    (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .overflow  (overflow)
  );

  function automatic exp_t mk(input logic [ACC_W-1:0] a, input logic [7:0] c, input logic o);
    exp_t e;
    e.acc = a;
    e.cnt = c;
    e.ovf = o;
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout: got in_ready %b, required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (out_valid !== 1'b1 && edges < 50) begin
      tick();
      edges++;
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (out_valid === 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    check("transfer_done", out_valid, 0);
  endtask

  // Monitor: compare each transferred result against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got acc %0d, required no result", out_acc);
        end else begin
          e = exp_q.pop_front();
          check("result_acc", out_acc, e.acc);
          check("result_count", out_count, e.cnt);
          check("result_overflow", overflow, e.ovf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_acc", out_acc, 0);
    check("reset_count", out_count, 0);
    check("reset_overflow", overflow, 0);

    // single beat
    exp_q.push_back(mk(15, 1, 0));
    beat(3, 5, 1);
    wait_valid(n);
    check("single_latency", n, 3);
    wait_idle();

    // four back-to-back max products
    exp_q.push_back(mk(260100, 4, 0));
    beat(255, 255, 0);
    beat(255, 255, 0);
    beat(255, 255, 0);
    beat(255, 255, 1);
    check("b2b_in_ready_after_last", in_ready, 0);
    wait_valid(n);
    check("b2b_latency", n, 3);
    wait_idle();

    // backpressure
    out_ready = 1'b0;
    exp_q.push_back(mk(26, 2, 0));
    beat(2, 3, 0);
    beat(4, 5, 1);
    wait_valid(n);
    check("bp_latency", n, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_acc_stable", out_acc, 26);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    wait_idle();
    exp_q.push_back(mk(1, 1, 0));
    beat(1, 1, 1);
    wait_valid(n);
    check("after_bp_latency", n, 3);
    wait_idle();

    // reset while draining discards the pending sum
    beat(10, 10, 0);
    beat(2, 2, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rst_drain_out_valid", out_valid, 0);
    end
    check("rst_drain_in_ready", in_ready, 1);
    exp_q.push_back(mk(49, 1, 0));
    beat(7, 7, 1);
    wait_valid(n);
    check("rst_drain_latency", n, 3);
    wait_idle();

    // bubbles inside a dot product
    exp_q.push_back(mk(5, 2, 0));
    beat(1, 1, 0);
    repeat (3) tick();
    beat(2, 2, 1);
    wait_valid(n);
    check("bubble_latency", n, 3);
    wait_idle();

    // 259 terms: count saturates at 255 and the 24-bit sum overflows
    exp_q.push_back(mk(OVF_ACC, 255, 1));
    for (int i = 0; i < 259; i++) begin
      beat(255, 255, (i == 258));
    end
    wait_valid(n);
    check("ovf_latency", n, 3);
    wait_idle();

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter WIDTH_IN, default 8, SHALL set the operand width; only 8 is supported.
REQ-002 Parameter ACC_W, default 24, SHALL set the accumulator width; legal range 16..32.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the synchronous, active-high reset.
REQ-005 Ports in_valid input 1, in_ready output 1: operand handshake; a beat transfers when both are high on a clk edge.
REQ-006 Ports in_a and in_b, input, WIDTH_IN each: unsigned operands; in_last, input, 1: marks the final term of a dot product.
REQ-007 Ports out_valid output 1, out_ready input 1: result handshake; a result transfers when both are high.
REQ-008 Port out_acc, output, ACC_W: the accumulated sum of products.
REQ-009 Port out_count, output, 8: the number of terms in the sum, saturating at 255.
REQ-010 Port overflow, output, 1: sticky flag, set if any sum exceeded 2^ACC_W-1.

Function
REQ-011 The datapath SHALL be 3 stages: S1 registers a, b, last, and a valid bit; S2 registers the 16-bit product, last, and valid; S3 holds the accumulator, the count, and the flag.
REQ-012 The FSM SHALL have states ACC, DRAIN and OUT.
REQ-013 In ACC, in_ready = 1; in DRAIN and OUT, in_ready = 0.
REQ-014 ACC -> DRAIN SHALL occur on an accepted beat with in_last = 1.
REQ-015 DRAIN -> OUT SHALL occur when the last-tagged product is added in S3.
REQ-016 OUT -> ACC SHALL occur on an out_valid && out_ready edge.
REQ-017 out_valid SHALL be 1 only in OUT.
REQ-018 Latency: a last beat accepted at edge N SHALL give out_valid = 1 after edge N+3.
REQ-019 In OUT, out_acc, out_count and overflow SHALL hold stable until the transfer.
REQ-020 On the transfer edge, the accumulator, count and overflow SHALL clear to 0, so the next dot product starts from 0 with no lost cycle.
REQ-021 The product SHALL be zero-extended to ACC_W before the add; the add is computed at ACC_W+1 bits, and the carry bit is the overflow event.
REQ-022 Back-to-back beats with in_valid held high SHALL be accepted one per cycle while in ACC.
REQ-023 A single-beat dot product (first beat has last = 1) SHALL be legal.
REQ-024 in_valid = 0 cycles inside a dot product SHALL insert bubbles only, with no effect on the sum.
REQ-025 out_count SHALL stop at 255, and accumulation SHALL continue beyond that.

Reset
REQ-026 When rst = 1, the FSM SHALL go to ACC, and all valid bits, the accumulator, out_count and overflow SHALL go to 0.
REQ-027 Reset values SHALL be: out_valid = 0 and in_ready = 1 from the first edge after rst is released.
REQ-028 Reset in any state, including mid-DRAIN or OUT, SHALL discard in-flight terms and the pending result.

Configuration
REQ-029 With macro MAC_ACCUMULATOR_SAT_EN defined, an overflowing add SHALL clamp the accumulator to 2^ACC_W-1 and set overflow.
REQ-030 Without MAC_ACCUMULATOR_SAT_EN, the add SHALL wrap modulo 2^ACC_W, and overflow SHALL still be set on carry.

Structure
REQ-031 A shared package mac_pkg SHALL hold the FSM state encoding (ACC = 2'd0, DRAIN = 2'd1, OUT = 2'd2) and the constant MAC_CNT_W = 8.
REQ-032 One sub-module SHALL be instantiated in S2: the team's combinational 8x8 unsigned multiplier, multiplyer, with WIDTH_IN = 8, fed from the S1 registers.
REQ-033 Everything else SHALL be flat in mac_accumulator.

Verification
REQ-034 Single beat: a = 3, b = 5, last = 1 at edge 0 -> out_valid after edge 3, out_acc = 15, out_count = 1, overflow = 0.
REQ-035 Four back-to-back beats of 255*255 (last on the 4th) with ACC_W = 24 -> out_acc = 260100, out_count = 4, in_ready = 0 from the edge after the last beat.
REQ-036 Backpressure: hold out_ready = 0 for 5 cycles in OUT -> out_acc stays stable and in_ready = 0; raise out_ready -> one transfer, then the next sum starts at 0.
REQ-037 Overflow with ACC_W = 16: two beats of 255*255 -> with SAT_EN, out_acc = 65535; without it, out_acc = 64514; overflow = 1 in both builds.
REQ-038 Reset mid-operation: assert rst in DRAIN after beats 10*10 and 2*2 -> out_valid = 0; a new beat 7*7, last = 1 -> out_acc = 49, out_count = 1.
REQ-039 Bubbles: beats 1*1, gap of 3 idle cycles, 2*2 with last = 1 -> out_acc = 5, out_count = 2.
